// File: rtl/simd_div_pkg.sv
// Shared definitions for the SIMD divider: lane modes, FSM states, result bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package simd_div_pkg;

  // Lane-mode encoding shared with the multiplier; any bitnum with bit 1 set selects 16-bit.
  localparam logic [1:0] MODE_4  = 2'b00;
  localparam logic [1:0] MODE_8  = 2'b01;
  localparam logic [1:0] MODE_16 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] quot;
    logic [15:0] rem;
    logic [3:0]  div0;
  } div_res_t;

  function automatic logic [4:0] lane_width(input logic [1:0] bitnum);
    if (bitnum[1]) return 5'd16;
    if (bitnum[0]) return 5'd8;
    return 5'd4;
  endfunction

endpackage

// File: rtl/simd_div_if.sv
// Request/response bundle between the execute stage and the SIMD divider.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored while busy.
interface simd_div_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [1:0]  bitnum;
  logic        sign_mode;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic [3:0]  div0;

  modport master (
    output start, A, B, bitnum, sign_mode,
    input  busy, done, quot, rem, div0
  );

  modport slave (
    input  start, A, B, bitnum, sign_mode,
    output busy, done, quot, rem, div0
  );
endinterface

// File: rtl/simd_div_lane.sv
// One W-bit divider lane: magnitude capture, restoring step, sign/zero/overflow fixup.
// Latency: W step cycles after load; fixed-up result is combinational from lane state.
// Backpressure: none; load and step are driven by the owning FSM.
module simd_div_lane
  #(parameter int W = 4)
  (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         sign_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dz
);

  logic [W-1:0] a_raw, b_raw, quo, prem, dvs;
  logic         sgn, q_neg, r_neg;
  logic         a_neg_in, b_neg_in;
  logic [W:0]   shifted, diff;
  logic         ge, ovf;

  assign a_neg_in = sign_mode & a[W-1];
  assign b_neg_in = sign_mode & b[W-1];

  // Partial remainder stays below the divisor, so one extra bit holds the shifted value.
  assign shifted = {prem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = shifted >= {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_raw <= '0;
      b_raw <= '0;
      quo   <= '0;
      prem  <= '0;
      dvs   <= '0;
      sgn   <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      a_raw <= a;
      b_raw <= b;
      sgn   <= sign_mode;
      quo   <= a_neg_in ? -a : a;
      dvs   <= b_neg_in ? -b : b;
      prem  <= '0;
      q_neg <= a_neg_in ^ b_neg_in;
      r_neg <= a_neg_in;
    end else if (step) begin
      prem <= ge ? diff[W-1:0] : shifted[W-1:0];
      quo  <= {quo[W-2:0], ge};
    end
  end

  assign dz  = (b_raw == '0);
  assign ovf = sgn && (a_raw == {1'b1, {(W-1){1'b0}}}) && (b_raw == '1);

  always_comb begin
    q = q_neg ? -quo : quo;
    r = r_neg ? -prem : prem;
    if (ovf) begin
      q = a_raw;
      r = '0;
    end
    if (dz) begin
      q = '1;
      r = a_raw;
    end
  end

endmodule

// File: rtl/simd_div.sv
// SIMD restoring divider (4x4 / 2x8 / 1x16 lanes) with start/busy/done handshake.
// Latency: done pulses W+1 edges after the accepting edge (W = lane width).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module simd_div
  import simd_div_pkg::*;
  (
  input  logic       clk,
  input  logic       rst_n,
  simd_div_if.slave  io
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  mode_q;
  logic        load, step, fin;
  logic        done_q;
  div_res_t    res_q, res_d;

  logic [15:0] q4, r4, q8, r8, q16, r16;
  logic [3:0]  dz4;
  logic [1:0]  dz8;
  logic        dz16;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = CALC;
          load    = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == 5'd1) state_d = SIGN;
      end
      SIGN: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_4;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (load) begin
        cnt_q  <= lane_width(io.bitnum);
        mode_q <= io.bitnum[1] ? MODE_16 : io.bitnum;
      end else if (step) begin
        cnt_q <= cnt_q - 5'd1;
      end
      if (fin) res_q <= res_d;
    end
  end

  // Every lane width runs on every request; only the captured mode's lanes are selected.
  for (genvar i = 0; i < 4; i++) begin : g_l4
    simd_div_lane #(.W(4)) u_lane (
      .clk, .rst_n, .load, .step,
      .sign_mode (io.sign_mode),
      .a         (io.A[4*i +: 4]),
      .b         (io.B[4*i +: 4]),
      .q         (q4[4*i +: 4]),
      .r         (r4[4*i +: 4]),
      .dz        (dz4[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_l8
    simd_div_lane #(.W(8)) u_lane (
      .clk, .rst_n, .load, .step,
      .sign_mode (io.sign_mode),
      .a         (io.A[8*i +: 8]),
      .b         (io.B[8*i +: 8]),
      .q         (q8[8*i +: 8]),
      .r         (r8[8*i +: 8]),
      .dz        (dz8[i])
    );
  end

  simd_div_lane #(.W(16)) u_l16 (
    .clk, .rst_n, .load, .step,
    .sign_mode (io.sign_mode),
    .a         (io.A),
    .b         (io.B),
    .q         (q16),
    .r         (r16),
    .dz        (dz16)
  );

  always_comb begin
    res_d = '0;
    unique case (mode_q)
      MODE_4: begin
        res_d.quot = q4;
        res_d.rem  = r4;
        res_d.div0 = dz4;
      end
      MODE_8: begin
        res_d.quot = q8;
        res_d.rem  = r8;
        res_d.div0 = {2'b00, dz8};
      end
      default: begin
        res_d.quot = q16;
        res_d.rem  = r16;
        res_d.div0 = {3'b000, dz16};
      end
    endcase
  end

  assign io.busy = (state_q != IDLE);
  assign io.done = done_q;
  assign io.quot = res_q.quot;
  assign io.rem  = res_q.rem;
  assign io.div0 = res_q.div0;

endmodule

// File: tb/tb_simd_div.sv
// Bench for simd_div: directed vector table, handshake/reset sequences, random ops vs model.
module tb_simd_div;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  simd_div_if dif ();

  simd_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  bn;
    logic        sm;
    logic [15:0] eq;
    logic [15:0] er;
    logic [3:0]  edz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] bn);
    return bn[1] ? 16 : (bn[0] ? 8 : 4);
  endfunction

  // Behavioural reference: per-lane integer division with the divider's special cases.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] bn, input logic sm,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic [3:0] dz);
    int w, n;
    longint ua, ub, av, bv, qv, rv, m, half;
    w    = width_of(bn);
    n    = 16 / w;
    m    = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    q = '0; r = '0; dz = '0;
    for (int i = 0; i < n; i++) begin
      ua = longint'(a >> (i * w)) & m;
      ub = longint'(b >> (i * w)) & m;
      av = (sm && ua >= half) ? ua - (m + 1) : ua;
      bv = (sm && ub >= half) ? ub - (m + 1) : ub;
      if (bv == 0) begin
        qv = -1; rv = av; dz[i] = 1'b1;
      end else if (sm && av == -half && bv == -1) begin
        qv = av; rv = 0;
      end else begin
        qv = av / bv; rv = av % bv;
      end
      q = q | 16'((qv & m) << (i * w));
      r = r | 16'((rv & m) << (i * w));
    end
  endfunction

  // Drives start for one edge, then counts edges until done; poke re-asserts start mid-flight.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] bn,
                        input logic sm, input int poke, output int lat, output int busy_n);
    dif.start = 1'b1; dif.A = a; dif.B = b; dif.bitnum = bn; dif.sign_mode = sm;
    @(posedge clk); #1;
    dif.start = 1'b0;
    dif.A = 16'($urandom); dif.B = 16'($urandom);
    dif.bitnum = 2'($urandom); dif.sign_mode = 1'($urandom);
    check("done_low_after_accept", dif.done, 0);
    busy_n = int'(dif.busy);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      busy_n += int'(dif.busy);
      if (dif.done) begin
        lat = c;
        dif.start = 1'b0;
        break;
      end
      dif.start = (c == poke);
    end
  endtask

  task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] bn, input logic sm, input logic [15:0] eq,
                          input logic [15:0] er, input logic [3:0] edz, input int poke);
    int lat, busy_n;
    run_op(a, b, bn, sm, poke, lat, busy_n);
    check({tag, "_latency"}, lat, width_of(bn) + 1);
    check({tag, "_busy_cycles"}, busy_n, width_of(bn) + 1);
    check({tag, "_quot"}, dif.quot, eq);
    check({tag, "_rem"}, dif.rem, er);
    check({tag, "_div0"}, dif.div0, edz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mq, mr, a, b, amin;
    logic [3:0]  mdz;
    logic [1:0]  bn;
    logic        sm;
    int          done_seen;

    vecs[0] = '{16'h0064, 16'h0007, 2'b10, 1'b1, 16'h000E, 16'h0002, 4'b0000};
    vecs[1] = '{16'hFF9C, 16'h0007, 2'b10, 1'b1, 16'hFFF2, 16'hFFFE, 4'b0000};
    vecs[2] = '{16'hFFFF, 16'h0010, 2'b10, 1'b0, 16'h0FFF, 16'h000F, 4'b0000};
    vecs[3] = '{16'h649C, 16'h07F9, 2'b01, 1'b1, 16'h0E0E, 16'h02FE, 4'b0000};
    vecs[4] = '{16'h7860, 16'h2F30, 2'b00, 1'b1, 16'h382F, 16'h1000, 4'b0001};
    vecs[5] = '{16'h8000, 16'hFFFF, 2'b11, 1'b1, 16'h8000, 16'h0000, 4'b0000};
    vecs[6] = '{16'h1234, 16'h0000, 2'b10, 1'b0, 16'hFFFF, 16'h1234, 4'b0001};
    vecs[7] = '{16'hFF10, 16'h0003, 2'b01, 1'b0, 16'hFF05, 16'hFF01, 4'b0010};
    vecs[8] = '{16'h8080, 16'hFFFF, 2'b01, 1'b1, 16'h8080, 16'h0000, 4'b0000};

    rst_n = 1'b1;
    dif.start = 1'b0; dif.A = '0; dif.B = '0; dif.bitnum = '0; dif.sign_mode = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("reset_busy", dif.busy, 0);
    check("reset_done", dif.done, 0);
    check("reset_quot", dif.quot, 0);
    check("reset_rem", dif.rem, 0);
    check("reset_div0", dif.div0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bn, vecs[i].sm,
               vecs[i].eq, vecs[i].er, vecs[i].edz, 0);

    // start pulsed mid-CALC must be dropped
    repeat (2) @(posedge clk);
    #1;
    check_op("poke16", 16'h0064, 16'h0007, 2'b10, 1'b1, 16'h000E, 16'h0002, 4'b0000, 6);
    check_op("poke4", 16'h7860, 16'h2F30, 2'b00, 1'b1, 16'h382F, 16'h1000, 4'b0001, 2);

    // back-to-back: second start lands in the done cycle of the first
    check_op("b2b_first", 16'h649C, 16'h07F9, 2'b01, 1'b1, 16'h0E0E, 16'h02FE, 4'b0000, 0);
    check_op("b2b_second", 16'hFFFF, 16'h0010, 2'b10, 1'b0, 16'h0FFF, 16'h000F, 4'b0000, 0);

    // asynchronous reset mid-CALC
    dif.start = 1'b1; dif.A = 16'h0064; dif.B = 16'h0007; dif.bitnum = 2'b10; dif.sign_mode = 1'b1;
    @(posedge clk); #1 dif.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", dif.busy, 0);
    check("midreset_done", dif.done, 0);
    check("midreset_quot", dif.quot, 0);
    check("midreset_rem", dif.rem, 0);
    check("midreset_div0", dif.div0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      done_seen += int'(dif.done);
    end
    check("midreset_no_done", done_seen, 0);
    check_op("after_reset", 16'hFF9C, 16'h0007, 2'b10, 1'b1, 16'hFFF2, 16'hFFFE, 4'b0000, 0);

    // random operations against the reference model
    for (int t = 0; t < 200; t++) begin
      bn = 2'($urandom);
      sm = 1'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) b[4*k +: 4] = 4'h0;
      if ($urandom_range(0, 9) == 0) begin
        amin = bn[1] ? 16'h8000 : (bn[0] ? 16'h8080 : 16'h8888);
        a = amin;
        b = 16'hFFFF;
      end
      model(a, b, bn, sm, mq, mr, mdz);
      check_op($sformatf("rnd%0d", t), a, b, bn, sm, mq, mr, mdz,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, width_of(bn)) : 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
